// File: rtl/ram_read_streamer_if.sv
// Command, RAM read port and output stream bundle for ram_read_streamer.
interface ram_read_streamer_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    input  cmd_ready, ram_raddr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    output cmd_ready, ram_raddr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/ram_read_streamer.sv
// Burst read sequencer for a 1-cycle-latency RAM; returning words are buffered
// in a small FIFO and presented as a valid/ready stream with a last flag.
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready high
//   READ   | issuing addresses while FIFO credit allows
//   DRAIN  | all addresses issued, waiting for the stream to empty
//   FINISH | one-cycle done pulse
module ram_read_streamer #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int LW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  ram_read_streamer_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] remaining;
  logic          inflight, inflight_last;
  logic [DW:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_nempty, issue, issue_last, push, pop;

  // a read in flight already owns a FIFO slot, so a pop never earns credit early
  assign issue       = (state == S_READ) && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
  assign issue_last  = issue && (remaining == LW'(1));
  assign push        = inflight;
  assign fifo_nempty = (count != '0);
  assign pop         = fifo_nempty && bus.out_ready;

  assign bus.ram_raddr = addr_q;
  assign bus.out_valid = fifo_nempty;
  assign bus.out_data  = fifo_nempty ? fifo_mem[rd_ptr][DW-1:0] : '0;
  assign bus.out_last  = fifo_nempty && fifo_mem[rd_ptr][DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.cmd_valid) state_nxt = (bus.cmd_len == '0) ? S_FINISH : S_READ;
      S_READ:   if (issue_last) state_nxt = S_DRAIN;
      S_DRAIN:  if (!inflight && !fifo_nempty && !pop) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE:   bus.cmd_ready = 1'b1;
      S_FINISH: begin bus.busy = 1'b1; bus.done = 1'b1; end
      default:  bus.busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
      if (state == S_IDLE && bus.cmd_valid) begin
        addr_q    <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (issue) begin
        addr_q    <= addr_q + AW'(1);
        remaining <= remaining - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_last, bus.ram_dout};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_read_streamer.sv
// Directed and randomized bursts against a queue-based model of the expected word stream.
module tb_ram_read_streamer;
  localparam int AW = 16, DW = 16, LW = 16, DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ram_read_streamer_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
  ram_read_streamer #(.AW(AW), .DW(DW), .LW(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) bus.ram_dout <= mem[bus.ram_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t % 4 == 0) || (t % 4 == 3);
      2:       return t >= 10;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // mode: 0 ready high, 1 pattern 1,0,0,1.., 2 ready low for 10 cycles, 3 random
  task automatic run_burst(input logic [AW-1:0] a, input int len, input int mode, input int stop_after);
    logic [DW:0]   expq[$];
    logic [DW:0]   e;
    logic [AW-1:0] issued;
    logic [DW-1:0] sd = '0;
    logic          sl = 1'b0;
    bit            stall = 0, seen_done = 0, exp_done;
    int            popped = 0, last_hs = -1;
    for (int i = 0; i < len; i++) expq.push_back({(i == len - 1), mem[AW'(a + i)]});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = LW'(len);
    bus.out_ready = ready_pat(mode, 0);
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    for (int t = 1; t < len * 4 + 40; t++) begin
      @(posedge clk); #1;
      bus.cmd_valid = (t == 1); bus.cmd_addr = ~a; bus.cmd_len = LW'(3);
      bus.out_ready = ready_pat(mode, t);
      @(negedge clk);
      if (t == 1) begin
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        chk("busy_high", bus.busy, 1);
      end
      issued = bus.ram_raddr - a;
      if (len == 0) chk("raddr_len0", bus.ram_raddr, a);
      else begin
        chk("issue_bound", (int'(issued) <= len) && (int'(issued) - popped <= DEPTH), 1);
        if (mode == 0 && t <= len + 1) chk("raddr_seq", bus.ram_raddr, AW'(a + t - 1));
        if (mode == 0 && t <= len + 2) chk("valid_timing", bus.out_valid, t >= 3);
        if (mode == 2 && t == 10) chk("stall_issues", issued, 4);
      end
      if (stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, sd);
        chk("stall_last", bus.out_last, sl);
      end
      if (expq.size() == 0) chk("extra_word", bus.out_valid, 0);
      else if (bus.out_valid && bus.out_ready) begin
        e = expq.pop_front();
        chk("out_data", bus.out_data, e[DW-1:0]);
        chk("out_last", bus.out_last, e[DW]);
        popped++;
        if (expq.size() == 0) last_hs = t;
      end
      stall = bus.out_valid && !bus.out_ready;
      sd = bus.out_data; sl = bus.out_last;
      exp_done = (len == 0) ? (t == 1) : (last_hs >= 0 && t == last_hs + 2);
      chk("done_pulse", bus.done, exp_done);
      if (stop_after > 0 && popped == stop_after) return;
      if (bus.done) begin seen_done = 1; break; end
    end
    chk("done_seen", seen_done, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("after_busy", bus.busy, 0);
    chk("after_done", bus.done, 0);
    chk("after_cmd_ready", bus.cmd_ready, 1);
    chk("after_raddr", bus.ram_raddr, AW'(a + len));
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = DW'(i + 'h100);
    #1;
    chk("rst_raddr", bus.ram_raddr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run_burst(16'h0010, 4, 0, 0);
    run_burst(16'h0010, 8, 1, 0);
    run_burst(16'hFFFE, 4, 0, 0);
    run_burst(16'h0020, 0, 0, 0);
    run_burst(16'h0030, 16, 2, 0);

    run_burst(16'h0040, 8, 0, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #2 rst = 1'b0;
    bus.out_ready = 1'b1; bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("postrst_valid", bus.out_valid, 0);
    run_burst(16'h0080, 2, 0, 0);

    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    repeat (6) run_burst(AW'($urandom), int'($urandom_range(0, 12)), 3, 0);
    run_burst(AW'($urandom), 9, 1, 0);
    run_burst(16'hFFFA, 10, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
